dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_W, default 10, word-address width (2^DEPTH_W x 32-bit words, 4 KiB).
REQ-002 SHALL have parameter RAM_BASE, default 32'h0000_0000, RAM region base; it is aligned to 2^(DEPTH_W+2).
REQ-003 SHALL have parameter MMIO_BASE, default 32'h1000_0000, MMIO region base (16-byte window).
REQ-004 SHALL have port clk_sys, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_sys, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port i_mem_wen, input, 1, word write request.
REQ-007 SHALL have port i_mem_ren, input, 1, word read request.
REQ-008 SHALL have port i_mem_addr, input, 32, byte address; bits [1:0] are ignored.
REQ-009 SHALL have port i_mem_wdata, input, 32, write data.
REQ-010 SHALL have port o_mem_rdata, output, 32, registered read data.
REQ-011 SHALL have port o_bus_err, output, 1, one-cycle pulse flagging an access to an unmapped address.
REQ-012 SHALL have port o_gpio, output, 32, GPIO_OUT register value.
REQ-013 SHALL have port o_timer_irq, output, 1, timer match flag level.

Function
REQ-014 SHALL decode a RAM hit as i_mem_addr[31:DEPTH_W+2] == RAM_BASE[31:DEPTH_W+2], with word index i_mem_addr[DEPTH_W+1:2].
REQ-015 SHALL write i_mem_wdata to the indexed RAM word at the clock edge where i_mem_wen=1 and the RAM hits.
REQ-016 SHALL return read data with a latency of exactly 1 cycle: o_mem_rdata is updated at the edge where i_mem_ren=1.
REQ-017 SHALL hold o_mem_rdata at its last value while i_mem_ren=0.
REQ-018 SHALL, when i_mem_wen=1 and i_mem_ren=1 target the same address in one cycle, perform the write and return the pre-write data (read-before-write).
REQ-019 SHALL return 32'h0 for a read of any unmapped address.
REQ-020 SHALL ignore writes to unmapped addresses.
REQ-021 SHALL pulse o_bus_err high for exactly one cycle, in the cycle after any unmapped access.
REQ-022 SHALL, in the MMIO window, map four registers at byte offsets +0x0, +0x4, +0x8 and +0xC (REQ-023 to REQ-026).
REQ-023 SHALL implement +0x0 as GPIO_OUT: read/write, driving o_gpio.
REQ-024 SHALL implement +0x4 as CYCLE_CNT: read-only free-running 32-bit counter that increments every cycle and wraps from FFFF_FFFF to 0; writes are ignored.
REQ-025 SHALL implement +0x8 as TIMER_CMP: read/write.
REQ-026 SHALL implement +0xC as TIMER_STAT: bit0 is MATCH, sticky; it sets in the cycle after CYCLE_CNT == TIMER_CMP, and a write with wdata[0]=1 clears it; bits [31:1] read 0.
REQ-027 SHALL give set priority over clear when a MATCH set and a write-1-to-clear occur in the same cycle.
REQ-028 SHALL drive o_timer_irq equal to MATCH.
REQ-029 SHALL return the pre-increment CYCLE_CNT value for a read of CYCLE_CNT.

Reset
REQ-030 SHALL, when rst_sys=1 at a clock edge, set o_mem_rdata=0, o_bus_err=0, GPIO_OUT=0, CYCLE_CNT=0, TIMER_CMP=0 and MATCH=0.
REQ-031 SHALL drop any access presented in a cycle with rst_sys=1, with no write and no o_bus_err.
REQ-032 SHALL NOT reset RAM contents.

Configuration
REQ-033 SHALL use macro DMEM_RESPONDER_MMIO_EN: when defined, the MMIO window and its registers are present per REQ-022 to REQ-029.
REQ-034 SHALL, when DMEM_RESPONDER_MMIO_EN is not defined, treat the MMIO window as unmapped, tie o_gpio to 0 and o_timer_irq to 0, and keep the port list unchanged.

Verification
REQ-035 SHALL cover: write 0xDEADBEEF at 0x0000_0010, then read 0x0000_0010 -> o_mem_rdata=0xDEADBEEF one cycle after ren.
REQ-036 SHALL cover: same-cycle wen+ren at 0x20 (old value 0x1, new value 0x2) -> rdata=0x1 next cycle; a following read -> 0x2.
REQ-037 SHALL cover: read at 0x2000_0000 -> rdata=0 and o_bus_err high for exactly 1 cycle; a write there -> no RAM change.
REQ-038 SHALL cover: write TIMER_CMP=20 after reset -> o_timer_irq rises the cycle after CYCLE_CNT=20; write 1 to 0x1000_000C -> irq low.
REQ-039 SHALL cover: write GPIO_OUT=0xA5A5_0F0F, then assert rst_sys together with a write to 0x4 -> o_gpio=0, and RAM word 1 is unchanged.
REQ-040 SHALL cover: build without DMEM_RESPONDER_MMIO_EN, read 0x1000_0004 -> rdata=0, o_bus_err pulses, o_gpio=0.

Source files
------------

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Single-port 32-bit data memory with optional MMIO (GPIO, cycle counter, timer) enabled by DMEM_RESPONDER_MMIO_EN.
// Read data is registered (1-cycle latency); every request is accepted, so there is no backpressure.
module dmem_responder #(
   parameter int          DEPTH_W   = 10,
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
   input  logic        clk_sys,
   input  logic        rst_sys,
   input  logic        i_mem_wen,
   input  logic        i_mem_ren,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   output logic [31:0] o_mem_rdata,
   output logic        o_bus_err,
   output logic [31:0] o_gpio,
   output logic        o_timer_irq
);

   localparam int WORDS = 1 << DEPTH_W;

   logic [31:0]        ram [WORDS];
   logic [DEPTH_W-1:0] word_idx;
   logic               ram_hit;
   logic               mmio_hit;
   logic               access;
   logic               unmapped;
   logic [31:0]        ram_rd;
   logic [31:0]        mmio_rd;
   logic [31:0]        rd_val;

   assign word_idx = i_mem_addr[DEPTH_W+1:2];
   assign ram_hit  = i_mem_addr[31:DEPTH_W+2] == RAM_BASE[31:DEPTH_W+2];
   assign access   = (i_mem_wen | i_mem_ren) & ~rst_sys;
   assign unmapped = access & ~ram_hit & ~mmio_hit;
   assign ram_rd   = ram[word_idx];

   // RAM contents survive reset; only the write is suppressed while reset is high.
   always_ff @(posedge clk_sys) begin
      if (!rst_sys && i_mem_wen && ram_hit) begin
         ram[word_idx] <= i_mem_wdata;
      end
   end

`ifdef DMEM_RESPONDER_MMIO_EN
   logic [1:0]  reg_sel;
   logic [31:0] gpio_out;
   logic [31:0] cycle_cnt;
   logic [31:0] timer_cmp;
   logic        match;
   logic        mmio_wen;
   logic        match_set;
   logic        match_clr;
   logic        unused_ok;

   assign mmio_hit  = i_mem_addr[31:4] == MMIO_BASE[31:4];
   assign reg_sel   = i_mem_addr[3:2];
   assign mmio_wen  = i_mem_wen & mmio_hit;
   assign match_set = cycle_cnt == timer_cmp;
   assign match_clr = mmio_wen & (reg_sel == 2'd3) & i_mem_wdata[0];
   assign unused_ok = ^i_mem_addr[1:0];

   always_comb begin
      mmio_rd = '0;
      case (reg_sel)
         2'd0:    mmio_rd = gpio_out;
         2'd1:    mmio_rd = cycle_cnt;
         2'd2:    mmio_rd = timer_cmp;
         default: mmio_rd = {31'b0, match};
      endcase
   end

   // A match in the same cycle as a clear wins, so no compare event is lost.
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         gpio_out  <= '0;
         cycle_cnt <= '0;
         timer_cmp <= '0;
         match     <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         match     <= match_set | (match & ~match_clr);
         if (mmio_wen && reg_sel == 2'd0) gpio_out  <= i_mem_wdata;
         if (mmio_wen && reg_sel == 2'd2) timer_cmp <= i_mem_wdata;
      end
   end

   assign o_gpio      = gpio_out;
   assign o_timer_irq = match;
`else
   logic unused_ok;

   assign mmio_hit    = 1'b0;
   assign mmio_rd     = '0;
   assign unused_ok   = ^{i_mem_addr[1:0], MMIO_BASE};
   assign o_gpio      = '0;
   assign o_timer_irq = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      if (ram_hit)       rd_val = ram_rd;
      else if (mmio_hit) rd_val = mmio_rd;
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         o_mem_rdata <= '0;
         o_bus_err   <= 1'b0;
      end else begin
         o_bus_err <= unmapped;
         if (i_mem_ren) o_mem_rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Bench for dmem_responder: directed vector table, timer/GPIO/reset sequences, then random traffic against a reference model.
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_MMIO_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif
   localparam logic [31:0] MMIO = 32'h1000_0000;

   logic        clk_sys = 1'b0;
   logic        rst_sys = 1'b1;
   logic        i_mem_wen = 1'b0;
   logic        i_mem_ren = 1'b0;
   logic [31:0] i_mem_addr = '0;
   logic [31:0] i_mem_wdata = '0;
   logic [31:0] o_mem_rdata;
   logic        o_bus_err;
   logic [31:0] o_gpio;
   logic        o_timer_irq;

   int total = 0;
   int bad = 0;

   // reference state
   logic [31:0] ram_m [1024];
   logic [31:0] rdata_m = '0, gpio_m = '0, cnt_m = '0, cmp_m = '0;
   logic        err_m = 1'b0, match_m = 1'b0;

   dmem_responder dut (
      .clk_sys    (clk_sys),
      .rst_sys    (rst_sys),
      .i_mem_wen  (i_mem_wen),
      .i_mem_ren  (i_mem_ren),
      .i_mem_addr (i_mem_addr),
      .i_mem_wdata(i_mem_wdata),
      .o_mem_rdata(o_mem_rdata),
      .o_bus_err  (o_bus_err),
      .o_gpio     (o_gpio),
      .o_timer_irq(o_timer_irq)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behaviour of one clock edge, derived from the register map description.
   task automatic model_edge(input logic r, input logic w, input logic rd,
                             input logic [31:0] a, input logic [31:0] wd);
      bit          in_ram, in_mmio, clr;
      logic [31:0] val;
      int          off;
      if (r) begin
         rdata_m = 0; err_m = 0; gpio_m = 0; cnt_m = 0; cmp_m = 0; match_m = 0;
         return;
      end
      in_ram  = (a >> 12) == 0;
      in_mmio = MMIO_EN && ((a & 32'hFFFF_FFF0) == MMIO);
      off     = int'((a >> 2) & 3);
      val     = 0;
      if (in_ram) val = ram_m[(a >> 2) & 1023];
      else if (in_mmio) begin
         if (off == 0) val = gpio_m;
         else if (off == 1) val = cnt_m;
         else if (off == 2) val = cmp_m;
         else val = {31'b0, match_m};
      end
      if (rd) rdata_m = val;
      err_m = (w || rd) && !in_ram && !in_mmio;
      clr = w && in_mmio && off == 3 && wd[0];
      match_m = (cnt_m == cmp_m) || (match_m && !clr);
      if (w && in_ram) ram_m[(a >> 2) & 1023] = wd;
      if (w && in_mmio && off == 0) gpio_m = wd;
      if (w && in_mmio && off == 2) cmp_m = wd;
      cnt_m = cnt_m + 1;
   endtask

   // Called at a negedge: drive, clock, then compare the DUT with the model at the next negedge.
   task automatic step(input logic r, input logic w, input logic rd,
                       input logic [31:0] a, input logic [31:0] wd);
      rst_sys = r; i_mem_wen = w; i_mem_ren = rd; i_mem_addr = a; i_mem_wdata = wd;
      @(posedge clk_sys);
      model_edge(r, w, rd, a, wd);
      @(negedge clk_sys);
      check("model_rdata", o_mem_rdata, rdata_m);
      check("model_err", {31'b0, o_bus_err}, {31'b0, err_m});
      check("model_gpio", o_gpio, MMIO_EN ? gpio_m : 32'h0);
      check("model_irq", {31'b0, o_timer_irq}, {31'b0, MMIO_EN ? match_m : 1'b0});
   endtask

   typedef struct {
      logic        wen;
      logic        ren;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h1,         1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h2,         1'b1, 32'h1,         1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         1'b1, 32'h2,         1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h2000_0000, 32'h0,         1'b1, 32'h0,         1'b1};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0,         1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h5A5A_5A5A, 1'b1, 32'h0,         1'b1};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b1, 32'hC0DE_0000, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0,         1'b1, 32'hC0DE_03FF, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,         1'b1, 32'h0,         1'b1};
      vecs[12] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};

      @(negedge clk_sys);
      step(1, 0, 0, 0, 0);
      check("rst_rdata", o_mem_rdata, 32'h0);
      check("rst_err", {31'b0, o_bus_err}, 32'h0);
      check("rst_gpio", o_gpio, 32'h0);

      for (int i = 0; i < 1024; i++) step(0, 1, 0, i << 2, 32'hC0DE_0000 | i);

      for (int i = 0; i < 13; i++) begin
         step(0, vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wd);
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), o_mem_rdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_err", i), {31'b0, o_bus_err}, {31'b0, vecs[i].exp_err});
      end

`ifdef DMEM_RESPONDER_MMIO_EN
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, MMIO + 8, 32'd20);       // cycle 0: CYCLE_CNT==TIMER_CMP==0
      check("irq_boot_match", {31'b0, o_timer_irq}, 32'h1);
      step(0, 1, 0, MMIO + 12, 32'h1);       // cycle 1
      check("irq_cleared", {31'b0, o_timer_irq}, 32'h0);
      for (int k = 2; k < 20; k++) begin
         if (k == 10) begin
            step(0, 0, 1, MMIO + 4, 0);
            check("cycle_cnt_read", o_mem_rdata, 32'd10);
         end else begin
            step(0, 0, 0, 0, 0);
         end
         check("irq_before_match", {31'b0, o_timer_irq}, 32'h0);
      end
      step(0, 0, 0, 0, 0);                   // cycle 20
      check("irq_rise", {31'b0, o_timer_irq}, 32'h1);
      step(0, 1, 0, MMIO + 12, 32'h1);       // cycle 21
      check("irq_w1c", {31'b0, o_timer_irq}, 32'h0);
      step(0, 1, 0, MMIO + 8, 32'd24);       // cycle 22
      step(0, 0, 0, 0, 0);                   // cycle 23
      step(0, 1, 0, MMIO + 12, 32'h1);       // cycle 24: set beats clear
      check("irq_set_priority", {31'b0, o_timer_irq}, 32'h1);
      step(0, 0, 1, MMIO + 12, 0);
      check("stat_read", o_mem_rdata, 32'h1);
      step(0, 1, 0, MMIO + 12, 32'h1);
      check("irq_final_clear", {31'b0, o_timer_irq}, 32'h0);
      step(0, 1, 0, MMIO, 32'hA5A5_0F0F);
      check("gpio_write", o_gpio, 32'hA5A5_0F0F);
      step(0, 0, 1, MMIO, 0);
      check("gpio_read", o_mem_rdata, 32'hA5A5_0F0F);
`else
      step(0, 0, 1, MMIO + 4, 0);
      check("nommio_rdata", o_mem_rdata, 32'h0);
      check("nommio_err", {31'b0, o_bus_err}, 32'h1);
      check("nommio_gpio", o_gpio, 32'h0);
      step(0, 1, 0, MMIO, 32'hA5A5_0F0F);
      check("nommio_gpio_wr", o_gpio, 32'h0);
      step(0, 0, 0, 0, 0);
      check("nommio_err_drop", {31'b0, o_bus_err}, 32'h0);
`endif
      step(1, 1, 0, 32'h4, 32'hFFFF_FFFF);
      check("rst_gpio_clear", o_gpio, 32'h0);
      check("rst_no_err", {31'b0, o_bus_err}, 32'h0);
      step(0, 0, 1, 32'h4, 0);
      check("rst_write_dropped", o_mem_rdata, 32'hC0DE_0001);

      for (int n = 0; n < 2000; n++) begin
         logic        r, w, rd;
         logic [31:0] a, wd;
         int          sel;
         r   = ($urandom_range(0, 49) == 0);
         w   = $urandom_range(0, 1);
         rd  = $urandom_range(0, 1);
         wd  = $urandom;
         sel = $urandom_range(0, 9);
         if (sel < 5)      a = ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
         else if (sel < 8) a = MMIO + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
         else if (sel < 9) a = 32'h2000_0000 + $urandom_range(0, 255);
         else              a = MMIO + 32'h10;
         if (sel >= 5 && sel < 8 && a[3:2] == 2'd2) wd = cnt_m + $urandom_range(0, 5);
         step(r, w, rd, a, wd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
